ysyx_22041071_ex_stage: RTL
===========================

// Module: ysyx_22041071_ex_stage
// PURPOSE
//  EX stage of the 5-stage RV64 pipeline; consumer side of the ID/EX valid/ready interface.
//  Takes operands/controls registered by ID, computes ALU/branch (optional M-ext), drives the
//  combinational EX forwarding path back to ID, and owns the EX/MEM pipeline register to MEM.
// PARAMETERS
//  XLEN      64  datapath width
//  DIV_ITERS 64  divider iterations for 64-bit ops (W ops use 32)
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous active-high reset
//  valid4       in   1    ID/EX entry valid
//  ready4       out  1    EX accepts ID/EX entry this cycle
//  PC4,Ins3     in   64,32 PC / instruction of the entry
//  ALU_ctrl2    in   5    op code (package enum)
//  src_a,src_b  in   64   operands, already forwarded by ID
//  rt_data1     in   64   store data
//  BImm2        in   12   branch offset [12:1]
//  Brch2,MEM_W_en2,WB_sel2,reg_w_en2 in 1  controls;  rdest1 in 5 dest reg
//  result       out  64   combinational EX result (forwarding)
//  rdest1_      out  5    forwarding dest;  reg_w_en3_ out 1 = valid4&reg_w_en2
//  brch_taken   out  1    one-cycle redirect pulse;  brch_target out 64
//  ready5       in   1    MEM ready;  valid5 out 1 EX/MEM valid
//  PC5,Ins4,ALU_res,rt_data2,rdest2_o,MEM_W_en3,WB_sel3,reg_w_en4  out  EX/MEM register
// BEHAVIOUR
//  - fire = valid4 & ready4. EX/MEM loads on fire; if ready5 & ~fire, valid5<=0 (bubble);
//    if ~ready5 EX/MEM holds. Reset: every EX/MEM output 0, FSM IDLE, brch_taken 0.
//  - ALU ops single-cycle: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND ADDW SUBW SLLW SRLW SRAW;
//    shifts use src_b[5:0] (W: [4:0]); W results = sext of low 32 bits.
//  - Branch: cond from Ins3[14:12] (BEQ/BNE/BLT/BGE/BLTU/BGEU) on src_a/src_b;
//    brch_taken = fire & Brch2 & cond; brch_target = PC4 + sext({BImm2,1'b0}).
//  - ready4 = ready5 for single-cycle ops; for DIV/REM ops see FSM.
//  - Divider FSM: IDLE -(valid4 & div op)-> BUSY (latch operands, ready4=0) -> count
//    DIV_ITERS (32 for W) restoring steps, 1 bit/cycle -> DONE (result latched, ready4=ready5)
//    -> IDLE on fire. Latency 64(32)+2 cycles from valid4 to fire.
//  - Div by zero: quotient = all ones, remainder = dividend. Signed MIN/-1: quotient = MIN,
//    remainder 0. Both resolved in DONE after full iteration count (fixed latency).
//  - reset mid-divide: FSM -> IDLE, partial result discarded; ID re-presents nothing (flushed).
//  - rdest1==0: reg_w_en3_ still follows reg_w_en2; ID ignores x0 itself.
// CONFIGURATION
//  YSYX_22041071_MULDIV_EN defined: MUL/MULH/MULHSU/MULHU/MULW single-cycle; DIV/DIVU/REM/REMU
//  and W forms via divider FSM. Undefined: codes 16-28 yield result 0, ready4=ready5,
//  no divider instantiated.
// STRUCTURE
//  Shared package/define: ALU_ctrl enum (0 ADD..14 SRAW, 16 MUL..28 REMUW), branch funct3
//  constants, XLEN. Sub-module: ysyx_22041071_div_iter (FSM + shift/subtract datapath,
//  start/busy/done, signed & W handling) instantiated only under the macro.
// TESTING
//  1 ADD src_a=5,src_b=7,ready5=1 -> result=12 same cycle, ALU_res=12,valid5=1 next cycle.
//  2 SUBW src_a=0,src_b=1 -> result=64'hFFFF_FFFF_FFFF_FFFF (sext of 32'hFFFF_FFFF).
//  3 BLT src_a=-1,src_b=0,PC4=0x8000_0000,BImm2=12'h008 -> brch_taken pulse,target=0x8000_0010.
//  4 DIV 100/7 (MULDIV_EN) -> ready4=0 for 65 cycles, then ALU_res=14; REM -> 2.
//  5 DIVU x/0 -> all ones; DIV MIN/-1 -> MIN; REM MIN/-1 -> 0.
//  6 ready5=0 for 3 cycles with valid4=1 -> EX/MEM holds, ready4=0, no double issue;
//    reset asserted in BUSY -> next cycle IDLE, valid5=0.

Source files
------------

// File: rtl/ysyx_22041071_ex_stage_pkg.sv
// EX stage shared definitions: ALU op codes, branch funct3 values,
// datapath widths and small helpers used by the EX stage and divider.
package ysyx_22041071_ex_stage_pkg;

  localparam int XLEN      = 64;
  localparam int DIV_ITERS = 64;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_ADDW   = 5'd10,
    ALU_SUBW   = 5'd11,
    ALU_SLLW   = 5'd12,
    ALU_SRLW   = 5'd13,
    ALU_SRAW   = 5'd14,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_MULW   = 5'd20,
    ALU_DIV    = 5'd21,
    ALU_DIVU   = 5'd22,
    ALU_REM    = 5'd23,
    ALU_REMU   = 5'd24,
    ALU_DIVW   = 5'd25,
    ALU_DIVUW  = 5'd26,
    ALU_REMW   = 5'd27,
    ALU_REMUW  = 5'd28
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMUW);
  endfunction

endpackage

// File: rtl/ysyx_22041071_ex_stage_div_iter.sv
// Restoring divider, one quotient bit per cycle (64 steps, 32 for W).
// Ports: start/op/a/b in, ack (EX fire) in, busy/done/result out.
module ysyx_22041071_div_iter
  import ysyx_22041071_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ack,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state, state_n;

  logic        w_op, s_op, r_op;
  logic        a_neg, b_neg;
  logic [63:0] a_x, b_x, a_mag, b_mag;

  logic [6:0]  cnt;
  logic [63:0] rem, quo, dsr, dvd;
  logic        w_q, r_q, neg_q, neg_r, zero_q;

  logic [64:0] sh, diff;
  logic [63:0] q_f, r_f, res;

  assign w_op = (op == ALU_DIVW) | (op == ALU_DIVUW)
              | (op == ALU_REMW) | (op == ALU_REMUW);
  assign s_op = (op == ALU_DIV)  | (op == ALU_REM)
              | (op == ALU_DIVW) | (op == ALU_REMW);
  assign r_op = (op == ALU_REM)  | (op == ALU_REMU)
              | (op == ALU_REMW) | (op == ALU_REMUW);

  // W forms see the low word extended to 64 bits, so one datapath
  // serves both widths.
  always_comb begin
    a_x = a;
    b_x = b;
    if (w_op) begin
      a_x = s_op ? sext32(a[31:0]) : {32'b0, a[31:0]};
      b_x = s_op ? sext32(b[31:0]) : {32'b0, b[31:0]};
    end
    a_neg = s_op & a_x[63];
    b_neg = s_op & b_x[63];
    a_mag = a_neg ? -a_x : a_x;
    b_mag = b_neg ? -b_x : b_x;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start)    state_n = S_BUSY;
      S_BUSY: if (cnt == 1) state_n = S_DONE;
      S_DONE: if (ack)      state_n = S_IDLE;
      default:              state_n = S_IDLE;
    endcase
  end

  assign sh   = {rem, quo[63]};
  assign diff = sh - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cnt    <= w_op ? 7'd32 : 7'(DIV_ITERS);
      rem    <= '0;
      // W dividend sits in the top word so its MSB shifts out first.
      quo    <= w_op ? {a_mag[31:0], 32'b0} : a_mag;
      dsr    <= b_mag;
      dvd    <= a_x;
      w_q    <= w_op;
      r_q    <= r_op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      zero_q <= (b_x == '0);
    end else if (state == S_BUSY) begin
      cnt <= cnt - 7'd1;
      if (!diff[64]) begin
        rem <= diff[63:0];
        quo <= {quo[62:0], 1'b1};
      end else begin
        rem <= sh[63:0];
        quo <= {quo[62:0], 1'b0};
      end
    end
  end

  // MIN/-1 falls out of the magnitude path; only /0 needs an override.
  always_comb begin
    q_f = neg_q ? -quo : quo;
    r_f = neg_r ? -rem : rem;
    if (zero_q) begin
      q_f = '1;
      r_f = dvd;
    end
    res    = r_q ? r_f : q_f;
    result = w_q ? sext32(res[31:0]) : res;
  end

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

endmodule

// File: rtl/ysyx_22041071_ex_stage.sv
// EX stage: ALU/branch, forwarding path to ID, EX/MEM register.
// M-extension (mul + iterative divider) under YSYX_22041071_MULDIV_EN.
module ysyx_22041071_ex_stage
  import ysyx_22041071_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid4,
  output logic        ready4,
  input  logic [63:0] PC4,
  input  logic [31:0] Ins3,
  input  logic [4:0]  ALU_ctrl2,
  input  logic [63:0] src_a,
  input  logic [63:0] src_b,
  input  logic [63:0] rt_data1,
  input  logic [11:0] BImm2,
  input  logic        Brch2,
  input  logic        MEM_W_en2,
  input  logic        WB_sel2,
  input  logic        reg_w_en2,
  input  logic [4:0]  rdest1,
  output logic [63:0] result,
  output logic [4:0]  rdest1_,
  output logic        reg_w_en3_,
  output logic        brch_taken,
  output logic [63:0] brch_target,
  input  logic        ready5,
  output logic        valid5,
  output logic [63:0] PC5,
  output logic [31:0] Ins4,
  output logic [63:0] ALU_res,
  output logic [63:0] rt_data2,
  output logic [4:0]  rdest2_o,
  output logic        MEM_W_en3,
  output logic        WB_sel3,
  output logic        reg_w_en4
);

  logic        fire, br_cond;
  logic [31:0] sraw;

  assign sraw = $signed(src_a[31:0]) >>> src_b[4:0];

`ifdef YSYX_22041071_MULDIV_EN
  logic          div_op, div_done, div_busy;
  logic [63:0]   div_res;
  logic          mul_sa, mul_sb;
  logic [127:0]  mul_p;

  assign div_op = is_div_op(ALU_ctrl2);
  assign ready4 = div_op ? (div_done & ready5) : ready5;

  assign mul_sa = ((ALU_ctrl2 == ALU_MULH) | (ALU_ctrl2 == ALU_MULHSU))
                & src_a[63];
  assign mul_sb = (ALU_ctrl2 == ALU_MULH) & src_b[63];
  assign mul_p  = {{64{mul_sa}}, src_a} * {{64{mul_sb}}, src_b};

  ysyx_22041071_div_iter u_div (
    .clk    (clk),
    .reset  (reset),
    .start  (valid4 & div_op),
    .ack    (fire),
    .op     (ALU_ctrl2),
    .a      (src_a),
    .b      (src_b),
    .busy   (div_busy),
    .done   (div_done),
    .result (div_res)
  );
`else
  assign ready4 = ready5;
`endif

  assign fire = valid4 & ready4;

  always_comb begin
    result = '0;
    case (ALU_ctrl2)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLL:  result = src_a << src_b[5:0];
      ALU_SLT:  result = {63'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: result = {63'b0, src_a < src_b};
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SRL:  result = src_a >> src_b[5:0];
      ALU_SRA:  result = $signed(src_a) >>> src_b[5:0];
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_ADDW: result = sext32(src_a[31:0] + src_b[31:0]);
      ALU_SUBW: result = sext32(src_a[31:0] - src_b[31:0]);
      ALU_SLLW: result = sext32(src_a[31:0] << src_b[4:0]);
      ALU_SRLW: result = sext32(src_a[31:0] >> src_b[4:0]);
      ALU_SRAW: result = sext32(sraw);
`ifdef YSYX_22041071_MULDIV_EN
      ALU_MUL:    result = mul_p[63:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = mul_p[127:64];
      ALU_MULW:   result = sext32(mul_p[31:0]);
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW:
                  result = div_res;
`endif
      default:  result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (Ins3[14:12])
      F3_BEQ:  br_cond = (src_a == src_b);
      F3_BNE:  br_cond = (src_a != src_b);
      F3_BLT:  br_cond = ($signed(src_a) <  $signed(src_b));
      F3_BGE:  br_cond = ($signed(src_a) >= $signed(src_b));
      F3_BLTU: br_cond = (src_a <  src_b);
      F3_BGEU: br_cond = (src_a >= src_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign brch_target = PC4 + {{51{BImm2[11]}}, BImm2, 1'b0};
  assign brch_taken  = ~reset & fire & Brch2 & br_cond;
  assign rdest1_     = rdest1;
  assign reg_w_en3_  = valid4 & reg_w_en2;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid5    <= 1'b0;
      PC5       <= '0;
      Ins4      <= '0;
      ALU_res   <= '0;
      rt_data2  <= '0;
      rdest2_o  <= '0;
      MEM_W_en3 <= 1'b0;
      WB_sel3   <= 1'b0;
      reg_w_en4 <= 1'b0;
    end else if (fire) begin
      valid5    <= 1'b1;
      PC5       <= PC4;
      Ins4      <= Ins3;
      ALU_res   <= result;
      rt_data2  <= rt_data1;
      rdest2_o  <= rdest1;
      MEM_W_en3 <= MEM_W_en2;
      WB_sel3   <= WB_sel2;
      reg_w_en4 <= reg_w_en2;
    end else if (ready5) begin
      valid5    <= 1'b0;
    end
  end

endmodule
